staged_mac_vec: RTL



---
 rtl/staged_mac_vec.sv | 132 +++++++++++++
 1 files changed

// File: rtl/staged_mac_vec.sv
// staged_mac_vec: 4-stage multi-lane signed fixed-point MAC over AXIS with adder tree and per-packet accumulate
// Define STAGED_MAC_SAT_EN to clamp results to the DATA_WIDTH range instead of wrapping.
module staged_mac_vec #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACCUM_BITS = 8,
  parameter int FRAC_BITS  = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  output logic                          SD_AXIS_TREADY,
  input  logic [LANES*2*DATA_WIDTH-1:0] SD_AXIS_TDATA,
  input  logic                          SD_AXIS_TLAST,
  input  logic                          SD_AXIS_TUSER,
  input  logic                          SD_AXIS_TVALID,
  input  logic [7:0]                    SD_AXIS_TID,
  output logic                          MO_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]         MO_AXIS_TDATA,
  output logic                          MO_AXIS_TLAST,
  input  logic                          MO_AXIS_TREADY,
  output logic [7:0]                    MO_AXIS_TID
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2*DW;
  localparam int SW = PW + $clog2(LANES);
  localparam int AW = PW + ACCUM_BITS;

  logic en, ld;
  logic s1_vld_q, s1_last_q, s1_user_q;
  logic [7:0] s1_id_q;
  logic [LANES*PW-1:0] s1_data_q;
  logic s2_vld_q, s2_last_q, s2_user_q;
  logic [7:0] s2_id_q;
  logic signed [DW-1:0] s2_bias_q;
  logic signed [PW-1:0] s2_prod_q [LANES];
  logic s3_vld_q, s3_last_q, s3_user_q;
  logic [7:0] s3_id_q;
  logic signed [DW-1:0] s3_bias_q;
  logic signed [SW-1:0] s3_sum_q;
  logic signed [AW-1:0] acc_q, acc_d, sum_ext, bias_ext;
  logic first_q, mo_vld_q, mo_vld_d;
  logic [DW-1:0] mo_data_q, res_d;
  logic [7:0] mo_id_q;
  logic signed [PW-1:0] prod_d [LANES];
  logic signed [SW-1:0] tree [2*LANES-1];

  assign en             = !(mo_vld_q && !MO_AXIS_TREADY);
  assign ld             = en && s3_vld_q && s3_last_q;
  assign SD_AXIS_TREADY = en && ARESETN;
  assign MO_AXIS_TVALID = mo_vld_q;
  assign MO_AXIS_TDATA  = mo_data_q;
  assign MO_AXIS_TLAST  = mo_vld_q;
  assign MO_AXIS_TID    = mo_id_q;
  assign mo_vld_d       = ld || (mo_vld_q && !MO_AXIS_TREADY);

  always_comb begin
    for (int i = 0; i < LANES; i++)
      prod_d[i] = PW'($signed(s1_data_q[i*PW+DW +: DW])) * PW'($signed(s1_data_q[i*PW +: DW]));
  end

  // heap-ordered tree: leaves at LANES-1.., node k sums children 2k+1 and 2k+2
  always_comb begin
    for (int i = 0; i < LANES; i++)
      tree[LANES-1+i] = SW'(s2_prod_q[i]);
    for (int k = LANES-2; k >= 0; k--)
      tree[k] = tree[2*k+1] + tree[2*k+2];
  end

  always_comb begin
    sum_ext  = {{(AW-SW){s3_sum_q[SW-1]}}, s3_sum_q};
    bias_ext = {{(AW-DW){s3_bias_q[DW-1]}}, s3_bias_q};
    acc_d    = s3_user_q ? bias_ext <<< FRAC_BITS : first_q ? sum_ext : acc_q + sum_ext;
  end

`ifdef STAGED_MAC_SAT_EN
  logic signed [AW-1:0] shr;
  logic ovf, sat_q;
  assign shr   = acc_d >>> FRAC_BITS;
  assign ovf   = !((&shr[AW-1:DW-1]) || !(|shr[AW-1:DW-1]));
  assign res_d = ovf ? {shr[AW-1], {(DW-1){!shr[AW-1]}}} : shr[DW-1:0];
  always_ff @(posedge ACLK) begin
    if (!ARESETN) sat_q <= 1'b0;
    else if (ld) sat_q <= ovf;
  end
`else
  assign res_d = acc_d[FRAC_BITS +: DW];
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      {s1_vld_q, s2_vld_q, s3_vld_q, mo_vld_q} <= '0;
      first_q   <= 1'b1;
      acc_q     <= '0;
      mo_data_q <= '0;
      mo_id_q   <= '0;
    end else begin
      mo_vld_q <= mo_vld_d;
      if (en) begin
        s1_vld_q <= SD_AXIS_TVALID;
        s2_vld_q <= s1_vld_q;
        s3_vld_q <= s2_vld_q;
      end
      if (en && s3_vld_q) begin
        acc_q   <= acc_d;
        first_q <= s3_last_q;
      end
      if (ld) begin
        mo_data_q <= res_d;
        mo_id_q   <= s3_id_q;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (en) begin
      s1_data_q <= SD_AXIS_TDATA;
      s1_last_q <= SD_AXIS_TLAST;
      s1_user_q <= SD_AXIS_TUSER;
      s1_id_q   <= SD_AXIS_TID;
      s2_prod_q <= prod_d;
      s2_bias_q <= $signed(s1_data_q[DW-1:0]);
      s2_last_q <= s1_last_q;
      s2_user_q <= s1_user_q;
      s2_id_q   <= s1_id_q;
      s3_sum_q  <= tree[0];
      s3_bias_q <= s2_bias_q;
      s3_last_q <= s2_last_q;
      s3_user_q <= s2_user_q;
      s3_id_q   <= s2_id_q;
    end
  end
endmodule
